sram_controller: RTL and testbench
==================================

// Module: sram_controller
// PURPOSE
//  Synchronous initiator for the asynchronous sram model's notCS/notOE/notWE interface.
//  Turns single-beat host read/write requests into correctly sequenced SRAM strobes.
//  Owns the bidirectional data bus and enforces setup, pulse and hold/turnaround phases.
//  Sits between the CPU memory stage and the sram instance.
// PARAMETERS
//  DATA_WIDTH  16  width of host data and of the SRAM data bus
//  ADDR_WIDTH  16  width of host address and of the SRAM address
//  WE_CYCLES    2  clocks notWE is held low per write (>=1)
//  RD_CYCLES    2  clocks notOE is held low before read data is sampled (>=1)
// PORTS
//  clock     in     1           rising-edge clock
//  reset     in     1           synchronous, active-high reset
//  reqValid  in     1           host request present
//  reqReady  out    1           controller can accept a request
//  reqWrite  in     1           1 = write, 0 = read
//  reqAddr   in     ADDR_WIDTH  request address
//  reqData   in     DATA_WIDTH  write data
//  rspValid  out    1           one-cycle pulse: rspData holds read result
//  rspData   out    DATA_WIDTH  read data
//  sramAddr  out    ADDR_WIDTH  SRAM address
//  sramData  inout  DATA_WIDTH  SRAM data bus, tri-stated unless writing
//  notCS     out    1           chip select, active low
//  notOE     out    1           output enable, active low
//  notWE     out    1           write enable, active low
// BEHAVIOUR
//  Reset and request handling
//  - Reset (sync, any state) gives: state IDLE; notCS=notOE=notWE=1; sramData=Z;
//    sramAddr=0; rspValid=0; rspData=0; reqReady=1; any in-flight request is dropped.
//  - All outputs are registered.
//  - reqReady=1 only in IDLE.
//  - A request is accepted on an edge where reqValid&&reqReady.
//    reqAddr, reqData and reqWrite are latched on that edge.
//  Write sequence (cycles counted from the first cycle after accept)
//  - W_SETUP, 1 cycle: notCS=0; sramAddr and sramData driven; notWE=1.
//  - W_PULSE, WE_CYCLES cycles: notWE=0; address and data held.
//  - W_HOLD, 1 cycle: notWE=1; data and address still driven; notCS=0.
//  - Return to IDLE: sramData=Z; notCS=1; reqReady=1.
//    Total write occupancy is WE_CYCLES+2 cycles.
//  Read sequence
//  - R_SETUP, 1 cycle: notCS=0; sramAddr driven; sramData=Z; notOE=1.
//  - R_ACCESS, RD_CYCLES cycles: notOE=0.
//    On the edge ending the last R_ACCESS cycle, rspData<=sramData.
//  - R_TURN, 1 cycle: notOE=1; rspValid=1 (exactly one cycle); bus stays Z.
//  - Return to IDLE.
//    Total read occupancy is RD_CYCLES+2 cycles.
//    rspData holds its value until the next read completes.
//  Sequencing and invariants
//  - A down-counter, wide enough for max(WE_CYCLES,RD_CYCLES), times PULSE and ACCESS.
//    It is loaded when entering those states.
//  - sramAddr keeps its last value in IDLE and is stable throughout every transaction.
//  - Invariants, all mandatory:
//    - notOE and notWE are never both 0.
//    - sramData is driven only while notOE=1 and state is W_*.
//    - notWE and notOE are 0 only while notCS=0.
//  - Back-to-back requests: the next request can be accepted in the IDLE cycle after the
//    HOLD or TURN phase. The minimum gap is 1 idle cycle between transactions.
//  - Reset during W_PULSE: notWE=1 and bus=Z from the next cycle. Memory contents at that
//    address are undefined.
//  - Requests are never queued. reqValid while reqReady=0 is ignored.
// TESTING (DATA_WIDTH=4, ADDR_WIDTH=4, WE_CYCLES=2, RD_CYCLES=2; sram preloaded, addr0=F, addr1=E)
//  1. Read addr 0, then addr 1 -> rspValid pulses with rspData=F, then E.
//     Each read has 4-cycle occupancy.
//  2. Write i to addr i for i=3..A, then read 3..A -> each rspData equals i.
//     No $display errors.
//  3. Single write -> notWE is low for exactly 2 clocks, inside a notCS-low window of 4 clocks.
//     Address and data are stable from W_SETUP through W_HOLD.
//  4. Hold reqValid high with alternating write/read to addr 5 (data 9) -> reqReady drops for
//     each transaction. The read returns 9.
//  5. Assert reset in the 2nd W_PULSE cycle -> next cycle notCS=notWE=notOE=1, sramData=Z,
//     reqReady=1. The following read of addr 3 completes normally.
//  6. Every cycle, an assertion checks for: no X/contention on sramData, no notOE&notWE
//     overlap, and no strobe low while notCS=1.

Source files
------------

// File: rtl/sram_controller.sv
// Synchronous initiator for an asynchronous SRAM notCS/notOE/notWE interface.
// Single-beat reads and writes with setup, pulse and hold/turnaround phases.
module sram_controller #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int WE_CYCLES  = 2,
   parameter int RD_CYCLES  = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  reqValid,
   output logic                  reqReady,
   input  logic                  reqWrite,
   input  logic [ADDR_WIDTH-1:0] reqAddr,
   input  logic [DATA_WIDTH-1:0] reqData,
   output logic                  rspValid,
   output logic [DATA_WIDTH-1:0] rspData,
   output logic [ADDR_WIDTH-1:0] sramAddr,
   inout  wire  [DATA_WIDTH-1:0] sramData,
   output logic                  notCS,
   output logic                  notOE,
   output logic                  notWE
);

   localparam int MAXC = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      R_SETUP,
      R_ACCESS,
      R_TURN
   } state_e;

   state_e                state_q;
   logic [CW-1:0]         cnt_q;
   logic                  ready_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  drive_q;
   logic                  cs_n_q;
   logic                  oe_n_q;
   logic                  we_n_q;

   // Bus is only ever driven during the W_* phases, where notOE stays high.
   assign sramData = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

   assign reqReady = ready_q;
   assign rspValid = rsp_valid_q;
   assign rspData  = rsp_data_q;
   assign sramAddr = addr_q;
   assign notCS    = cs_n_q;
   assign notOE    = oe_n_q;
   assign notWE    = we_n_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         drive_q     <= 1'b0;
         cs_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (reqValid && ready_q) begin
                  ready_q <= 1'b0;
                  cs_n_q  <= 1'b0;
                  addr_q  <= reqAddr;
                  wdata_q <= reqData;
                  if (reqWrite) begin
                     state_q <= W_SETUP;
                     drive_q <= 1'b1;
                  end else begin
                     state_q <= R_SETUP;
                  end
               end
            end
            W_SETUP: begin
               state_q <= W_PULSE;
               we_n_q  <= 1'b0;
               cnt_q   <= CW'(WE_CYCLES - 1);
            end
            W_PULSE: begin
               if (cnt_q == '0) begin
                  state_q <= W_HOLD;
                  we_n_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            W_HOLD: begin
               state_q <= IDLE;
               drive_q <= 1'b0;
               cs_n_q  <= 1'b1;
               ready_q <= 1'b1;
            end
            R_SETUP: begin
               state_q <= R_ACCESS;
               oe_n_q  <= 1'b0;
               cnt_q   <= CW'(RD_CYCLES - 1);
            end
            R_ACCESS: begin
               if (cnt_q == '0) begin
                  state_q     <= R_TURN;
                  oe_n_q      <= 1'b1;
                  rsp_data_q  <= sramData;
                  rsp_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            R_TURN: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               cs_n_q      <= 1'b1;
               ready_q     <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               drive_q <= 1'b0;
               cs_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
               we_n_q  <= 1'b1;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM.
// Protocol invariants are checked on every falling edge.
module tb_sram_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       reqValid;
   logic       reqReady;
   logic       reqWrite;
   logic [3:0] reqAddr;
   logic [3:0] reqData;
   logic       rspValid;
   logic [3:0] rspData;
   logic [3:0] sramAddr;
   wire  [3:0] sramData;
   logic       notCS;
   logic       notOE;
   logic       notWE;

   logic [3:0] mem [16];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic       inv_on = 1'b0;

   always #5 clock = ~clock;

   sram_controller #(
      .DATA_WIDTH(4),
      .ADDR_WIDTH(4),
      .WE_CYCLES (2),
      .RD_CYCLES (2)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .reqValid(reqValid),
      .reqReady(reqReady),
      .reqWrite(reqWrite),
      .reqAddr (reqAddr),
      .reqData (reqData),
      .rspValid(rspValid),
      .rspData (rspData),
      .sramAddr(sramAddr),
      .sramData(sramData),
      .notCS   (notCS),
      .notOE   (notOE),
      .notWE   (notWE)
   );

   // Async SRAM: drives on CS&OE, latches on the rising edge of WE.
   assign sramData = (!notCS && !notOE) ? mem[sramAddr] : 4'bzzzz;

   always @(posedge notWE) begin
      if (!notCS) mem[sramAddr] <= sramData;
   end

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (inv_on) begin
         chk("inv_oe_we", {31'd0, notOE | notWE}, 1);
         chk("inv_cs", {31'd0, notCS && !(notOE && notWE)}, 0);
         if (!notCS && !notOE)
            chk("inv_bus", {28'd0, sramData}, {28'd0, mem[sramAddr]});
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic accept(input logic wr, input logic [3:0] a,
                         input logic [3:0] d);
      int t;
      reqValid = 1'b1;
      reqWrite = wr;
      reqAddr  = a;
      reqData  = d;
      t = 0;
      while (!reqReady && t < 20) begin
         tick();
         t++;
      end
      if (t >= 20) chk("acc_timeout", 0, 1);
      tick();
      reqValid = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [3:0] a,
                          input logic [3:0] exp);
      int n;
      accept(1'b0, a, 4'h0);
      n = 1;
      while (!rspValid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_occ"}, n, 4);
      chk({tag, "_data"}, {28'd0, rspData}, {28'd0, exp});
      tick();
      chk({tag, "_vpulse"}, {31'd0, rspValid}, 0);
      chk({tag, "_rdy"}, {31'd0, reqReady}, 1);
   endtask

   task automatic do_write(input string tag, input logic [3:0] a,
                           input logic [3:0] d);
      int cs;
      int we;
      int bad;
      accept(1'b1, a, d);
      cs  = 0;
      we  = 0;
      bad = 0;
      while (!notCS && cs < 20) begin
         if (!notWE) we++;
         if (sramAddr !== a || sramData !== d) bad++;
         cs++;
         tick();
      end
      chk({tag, "_cs"}, cs, 4);
      chk({tag, "_we"}, we, 2);
      chk({tag, "_stable"}, bad, 0);
      chk({tag, "_rdy"}, {31'd0, reqReady}, 1);
   endtask

   initial begin
      int t;
      for (int i = 0; i < 16; i++) mem[i] = 4'h0;
      mem[0] = 4'hF;
      mem[1] = 4'hE;
      reset    = 1'b1;
      reqValid = 1'b0;
      reqWrite = 1'b0;
      reqAddr  = 4'h0;
      reqData  = 4'h0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_cs", {31'd0, notCS}, 1);
      chk("rst_oe", {31'd0, notOE}, 1);
      chk("rst_we", {31'd0, notWE}, 1);
      chk("rst_rdy", {31'd0, reqReady}, 1);
      chk("rst_rv", {31'd0, rspValid}, 0);
      chk("rst_rd", {28'd0, rspData}, 0);
      chk("rst_addr", {28'd0, sramAddr}, 0);
      inv_on = 1'b1;

      do_read("t1_r0", 4'h0, 4'hF);
      do_read("t1_r1", 4'h1, 4'hE);
      chk("t1_hold", {28'd0, rspData}, 32'hE);

      for (int i = 3; i <= 10; i++)
         do_write($sformatf("t2_w%0d", i), 4'(i), 4'(i));
      for (int i = 3; i <= 10; i++)
         do_read($sformatf("t2_r%0d", i), 4'(i), 4'(i));

      do_write("t3", 4'hC, 4'h6);
      chk("t3_addr_idle", {28'd0, sramAddr}, 32'hC);

      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqAddr  = 4'h5;
      reqData  = 4'h9;
      tick();
      chk("t4_w_rdy", {31'd0, reqReady}, 0);
      reqWrite = 1'b0;
      reqData  = 4'h0;
      t = 0;
      while (!reqReady && t < 20) begin
         tick();
         t++;
      end
      chk("t4_w_occ", t, 4);
      tick();
      chk("t4_r_rdy", {31'd0, reqReady}, 0);
      reqValid = 1'b0;
      t = 1;
      while (!rspValid && t < 20) begin
         tick();
         t++;
      end
      chk("t4_r_occ", t, 4);
      chk("t4_r_data", {28'd0, rspData}, 32'h9);
      tick();

      accept(1'b1, 4'h3, 4'h5);
      tick();
      tick();
      chk("t5_inpulse", {31'd0, notWE}, 0);
      inv_on = 1'b0;
      reset  = 1'b1;
      tick();
      reset  = 1'b0;
      inv_on = 1'b1;
      chk("t5_cs", {31'd0, notCS}, 1);
      chk("t5_we", {31'd0, notWE}, 1);
      chk("t5_oe", {31'd0, notOE}, 1);
      chk("t5_rdy", {31'd0, reqReady}, 1);
      accept(1'b0, 4'h3, 4'h0);
      t = 1;
      while (!rspValid && t < 20) begin
         tick();
         t++;
      end
      chk("t5_r_occ", t, 4);
      tick();
      chk("t5_r_rdy", {31'd0, reqReady}, 1);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
